uart_mem_responder: RTL and testbench

UART_MEM_RESPONDER -- requirements
Module: uart_mem_responder

---
 rtl/uart_mem_responder.sv | 168 ++++++++++++++++
 tb/tb_uart_mem_responder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mem_responder.sv
// Byte-oriented UART memory responder: decodes opcode/address packets and
// serves reads or writes against an internal byte-wide RAM.
module uart_mem_responder #(
  parameter int         MEM_AW   = 17,
  parameter logic [7:0] ACK_BYTE = 8'hA5,
  parameter logic [7:0] ERR_BYTE = 8'hEE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  recv_data,
  input  logic        recv_avail,
  output logic        recv_en,
  output logic [7:0]  send_data,
  input  logic        send_avail,
  output logic        send_en,
  output logic        busy,
  output logic [15:0] pkt_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_OPC_ADDR, S_WDATA, S_RREQ, S_RSEND, S_WACK, S_ERR
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [1:0]          idx_q, idx_d;
  logic [1:0]          last_q, last_d;
  logic                wr_q, wr_d;
  logic [MEM_AW-1:0]   addr_q, addr_d;
  logic [15:0]         pkt_q, pkt_d;

  logic [7:0]          mem [2**MEM_AW];
  logic [7:0]          rdata_q;
  logic                mem_we, mem_re;
  logic [MEM_AW-1:0]   ea;

  assign ea      = addr_q + {{(MEM_AW-2){1'b0}}, idx_q};
  assign busy    = (state_q != S_IDLE);
  assign pkt_cnt = pkt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      last_q  <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      pkt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      pkt_q   <= pkt_d;
    end
  end

  // RAM is deliberately outside reset so a mid-packet reset keeps stored bytes.
  always_ff @(posedge clk) begin
    if (mem_we) mem[ea] <= recv_data;
    if (mem_re) rdata_q <= mem[ea];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    last_d    = last_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    pkt_d     = pkt_q;
    recv_en   = 1'b0;
    send_en   = 1'b0;
    send_data = 8'h00;
    mem_we    = 1'b0;
    mem_re    = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (recv_avail) state_d = S_OPC_ADDR;
      end

      S_OPC_ADDR: begin
        if (recv_avail) begin
          recv_en = 1'b1;
          if (cnt_q == 3'd0) begin
            wr_d  = recv_data[0];
            cnt_d = 3'd1;
            case (recv_data[2:1])
              2'd0:    last_d = 2'd0;
              2'd1:    last_d = 2'd1;
              2'd2:    last_d = 2'd3;
              default: begin
                state_d = S_ERR;
                cnt_d   = '0;
              end
            endcase
          end else begin
            // little-endian address; bytes beyond MEM_AW bits are dropped
            for (int b = 0; b < MEM_AW; b++) begin
              if ((b / 8) + 1 == int'(cnt_q)) addr_d[b] = recv_data[3'(b % 8)];
            end
            if (cnt_q == 3'd4) begin
              idx_d   = '0;
              cnt_d   = '0;
              state_d = wr_q ? S_WDATA : S_RREQ;
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
      end

      S_WDATA: begin
        if (recv_avail) begin
          recv_en = 1'b1;
          mem_we  = 1'b1;
          if (idx_q == last_q) state_d = S_WACK;
          else                 idx_d   = idx_q + 2'd1;
        end
      end

      S_RREQ: begin
        mem_re  = 1'b1;
        state_d = S_RSEND;
      end

      S_RSEND: begin
        send_data = rdata_q;
        if (send_avail) begin
          send_en = 1'b1;
          if (idx_q == last_q) begin
            pkt_d   = pkt_q + 16'd1;
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = S_RREQ;
          end
        end
      end

      S_WACK: begin
        send_data = ACK_BYTE;
        if (send_avail) begin
          send_en = 1'b1;
          pkt_d   = pkt_q + 16'd1;
          state_d = S_IDLE;
        end
      end

      S_ERR: begin
        send_data = ERR_BYTE;
        if (send_avail) begin
          send_en = 1'b1;
          pkt_d   = pkt_q + 16'd1;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_mem_responder.sv
// Randomized scoreboard bench for uart_mem_responder: a FIFO-style link model
// feeds bytes, a packet-level memory model predicts every response byte.
module tb_uart_mem_responder;
  localparam int AW = 17;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  recv_data = 8'h00;
  logic        recv_avail = 1'b0;
  logic        recv_en;
  logic [7:0]  send_data;
  logic        send_avail = 1'b0;
  logic        send_en;
  logic        busy;
  logic [15:0] pkt_cnt;

  always #5 clk = ~clk;

  uart_mem_responder #(.MEM_AW(AW), .ACK_BYTE(8'hA5), .ERR_BYTE(8'hEE)) dut (
    .clk(clk), .rst(rst),
    .recv_data(recv_data), .recv_avail(recv_avail), .recv_en(recv_en),
    .send_data(send_data), .send_avail(send_avail), .send_en(send_en),
    .busy(busy), .pkt_cnt(pkt_cnt)
  );

  typedef struct { logic [7:0] d; bit last; } resp_t;

  logic [7:0] rx_q[$];
  resp_t      exp_q[$];
  logic [7:0] mem_m [int];
  int         n_cmp = 0, n_fail = 0;
  int         exp_pkts = 0;
  int         recv_gap_pct = 0, send_gap_pct = 0;
  bit         hold_send = 1'b0;
  bit         pop_pend = 1'b0, chk_pkt = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] mem_val(input logic [31:0] a);
    int k = int'(a[AW-1:0]);
    return mem_m.exists(k) ? mem_m[k] : 8'h00;
  endfunction

  // link side: consumes a byte at the edge where recv_en was seen, then re-rolls availability
  always @(posedge clk) begin
    #1;
    if (pop_pend && rx_q.size() > 0) void'(rx_q.pop_front());
    recv_avail = (rx_q.size() > 0) && ($urandom_range(99) >= recv_gap_pct);
    recv_data  = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
    send_avail = !hold_send && ($urandom_range(99) >= send_gap_pct);
  end

  always @(negedge clk) begin
    resp_t e;
    if (rst) begin
      pop_pend = 1'b0;
      chk_pkt  = 1'b0;
      exp_pkts = 0;
    end else begin
      if (chk_pkt) check("pkt_cnt", {16'h0, pkt_cnt}, exp_pkts & 32'hFFFF);
      chk_pkt  = 1'b0;
      pop_pend = recv_en;
      if (recv_en) check("recv_en_without_avail", {31'h0, recv_avail}, 1);
      if (send_en) begin
        check("send_en_without_avail", {31'h0, send_avail}, 1);
        check("busy_while_sending", {31'h0, busy}, 1);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_send: got %0h, want no byte", send_data);
        end else begin
          e = exp_q.pop_front();
          check("send_data", {24'h0, send_data}, {24'h0, e.d});
          if (e.last) begin
            exp_pkts++;
            chk_pkt = 1'b1;
          end
        end
      end
    end
  end

  // Packet-level model: decode opcode, queue the link bytes, predict the reply.
  task automatic send_pkt(input logic [7:0] opc, input logic [31:0] a,
                          input logic [31:0] wd);
    int len;
    logic [31:0] ai;
    rx_q.push_back(opc);
    if (opc[2:1] == 2'd3) begin
      exp_q.push_back('{8'hEE, 1'b1});
      return;
    end
    len = 1 << opc[2:1];
    for (int i = 0; i < 4; i++) rx_q.push_back(a[8*i +: 8]);
    for (int i = 0; i < len; i++) begin
      ai = a + i;
      if (opc[0]) begin
        rx_q.push_back(wd[8*i +: 8]);
        mem_m[int'(ai[AW-1:0])] = wd[8*i +: 8];
      end else begin
        exp_q.push_back('{mem_val(ai), i == len - 1});
      end
    end
    if (opc[0]) exp_q.push_back('{8'hA5, 1'b1});
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!(rx_q.size() == 0 && exp_q.size() == 0 && !busy) && n < budget) begin
      @(negedge clk); #2;
      n++;
    end
    if (n >= budget) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_idle_timeout: got %0d pending replies, want 0", exp_q.size());
    end
    @(negedge clk); #2;
    @(negedge clk); #2;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_recv_en"},   {31'h0, recv_en}, 0);
    check({tag, "_send_en"},   {31'h0, send_en}, 0);
    check({tag, "_send_data"}, {24'h0, send_data}, 0);
    check({tag, "_busy"},      {31'h0, busy}, 0);
    check({tag, "_pkt_cnt"},   {16'h0, pkt_cnt}, 0);
  endtask

  initial begin
    logic [31:0] a;
    int n;
    #1;
    check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // write 4 at 0x100, read back, invalid opcode, wrap write/read, unwritten read
    send_pkt(8'h05, 32'h0000_0100, 32'hEFBE_ADDE);
    wait_idle(500);
    check("pkt_after_write", {16'h0, pkt_cnt}, 1);
    send_pkt(8'h04, 32'h0000_0100, 32'h0);
    wait_idle(500);
    check("pkt_after_read", {16'h0, pkt_cnt}, 2);
    send_pkt(8'h07, 32'h0, 32'h0);
    send_pkt(8'h03, 32'h0001_FFFF, 32'h0000_2211);
    send_pkt(8'h02, 32'h0001_FFFF, 32'h0);
    send_pkt(8'h00, 32'h0000_0000, 32'h0);
    send_pkt(8'h04, 32'hFFFE_5000, 32'h0);
    wait_idle(1000);
    check("pkt_after_directed", {16'h0, pkt_cnt}, 7);

    // transmit backpressure for 50 cycles during a 4-byte read
    hold_send = 1'b1;
    send_pkt(8'h04, 32'h0000_0100, 32'h0);
    n = 0;
    while (rx_q.size() > 0 && n < 200) begin @(negedge clk); #2; n++; end
    repeat (50) @(negedge clk);
    #2;
    check("busy_under_backpressure", {31'h0, busy}, 1);
    check("replies_held", exp_q.size(), 4);
    hold_send = 1'b0;
    wait_idle(500);

    // receive gaps mid-write
    recv_gap_pct = 70;
    send_pkt(8'h05, 32'h0000_0180, 32'h4433_2211);
    send_pkt(8'h04, 32'h0000_0180, 32'h0);
    wait_idle(2000);
    recv_gap_pct = 0;

    // reset after 2 of 4 write data bytes
    rx_q.push_back(8'h05);
    rx_q.push_back(8'h00); rx_q.push_back(8'h02);
    rx_q.push_back(8'h00); rx_q.push_back(8'h00);
    rx_q.push_back(8'h12); rx_q.push_back(8'h34);
    mem_m[32'h200] = 8'h12;
    mem_m[32'h201] = 8'h34;
    n = 0;
    while (rx_q.size() > 0 && n < 200) begin @(negedge clk); #2; n++; end
    repeat (3) @(negedge clk);
    #2;
    check("busy_mid_write", {31'h0, busy}, 1);
    rst = 1'b1;
    #1;
    check_reset_outputs("midreset");
    @(posedge clk); #2;
    rx_q.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    send_pkt(8'h04, 32'h0000_0200, 32'h0);
    wait_idle(500);
    check("pkt_after_reset_read", {16'h0, pkt_cnt}, 1);

    // randomized packet stream, queued back to back
    recv_gap_pct = 25;
    send_gap_pct = 25;
    for (int p = 0; p < 60; p++) begin
      case ($urandom_range(3))
        0:       a = 32'h300 + $urandom_range(15);
        1:       a = 32'h1FFF0 + $urandom_range(15);
        2:       a = $urandom;
        default: a = {$urandom_range(32767), 17'h00300} + $urandom_range(15);
      endcase
      send_pkt(8'($urandom), a, $urandom);
    end
    wait_idle(20000);
    check("final_pkt_cnt", {16'h0, pkt_cnt}, exp_pkts & 32'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
